// File: rtl/salamander_sram_busctrl_if.sv
`default_nettype none
// ==== salamander_sram_busctrl_if : 68000 CPU-side and byte-lane SRAM-side signal bundle ====
// ==== rev 1.0 ====
interface salamander_sram_busctrl_if #(
  parameter int AW = 10
);
  logic          i_CS;
  logic          i_AS_n;
  logic          i_UDS_n;
  logic          i_LDS_n;
  logic          i_RW;
  logic [AW-1:0] i_CPU_ADDR;
  logic [15:0]   i_CPU_DIN;
  logic [15:0]   o_CPU_DOUT;
  logic          o_DTACK_n;
  logic          o_BUSY;
  logic [AW-1:0] o_RAM_ADDR;
  logic [15:0]   o_RAM_DIN;
  logic          o_RAM_RD_HI;
  logic          o_RAM_RD_LO;
  logic          o_RAM_WR_HI;
  logic          o_RAM_WR_LO;
  logic [7:0]    i_RAM_DOUT_HI;
  logic [7:0]    i_RAM_DOUT_LO;

  modport slave (
    input  i_CS, i_AS_n, i_UDS_n, i_LDS_n, i_RW, i_CPU_ADDR, i_CPU_DIN,
    input  i_RAM_DOUT_HI, i_RAM_DOUT_LO,
    output o_CPU_DOUT, o_DTACK_n, o_BUSY, o_RAM_ADDR, o_RAM_DIN,
    output o_RAM_RD_HI, o_RAM_RD_LO, o_RAM_WR_HI, o_RAM_WR_LO
  );

  modport master (
    output i_CS, i_AS_n, i_UDS_n, i_LDS_n, i_RW, i_CPU_ADDR, i_CPU_DIN,
    output i_RAM_DOUT_HI, i_RAM_DOUT_LO,
    input  o_CPU_DOUT, o_DTACK_n, o_BUSY, o_RAM_ADDR, o_RAM_DIN,
    input  o_RAM_RD_HI, o_RAM_RD_LO, o_RAM_WR_HI, o_RAM_WR_LO
  );
endinterface
`default_nettype wire

// File: rtl/salamander_sram_busctrl.sv
`default_nettype none
// ==== salamander_sram_busctrl : 68000 bus cycles to single-cycle byte-lane SRAM strobes + fill ====
// ==== rev 1.0 ====
module salamander_sram_busctrl #(
  parameter int         AW        = 10,
  parameter bit         CLEAR_EN  = 1'b1,
  parameter logic [7:0] CLEAR_VAL = 8'h00
) (
  input wire                       i_MCLK,
  input wire                       i_RST_n,
  salamander_sram_busctrl_if.slave bus_io
);

  localparam logic [2:0]    S_CLEAR   = 3'd0;
  localparam logic [2:0]    S_IDLE    = 3'd1;
  localparam logic [2:0]    S_ISSUE   = 3'd2;
  localparam logic [2:0]    S_CAPTURE = 3'd3;
  localparam logic [2:0]    S_ACK     = 3'd4;
  localparam logic [2:0]    S_RESET   = CLEAR_EN ? S_CLEAR : S_IDLE;
  localparam logic [AW-1:0] ADDR_LAST = '1;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic [15:0]   dout_q, dout_d;
  logic          rw_q, rw_d;
  logic          hi_q, hi_d;
  logic          lo_q, lo_d;
  logic          dtack_n_q, dtack_n_d;
  logic          busy_q, busy_d;
  logic          rd_hi_q, rd_hi_d;
  logic          rd_lo_q, rd_lo_d;
  logic          wr_hi_q, wr_hi_d;
  logic          wr_lo_q, wr_lo_d;
  logic          w_start;

  assign w_start = bus_io.i_CS & ~bus_io.i_AS_n & (~bus_io.i_UDS_n | ~bus_io.i_LDS_n);

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q   <= S_RESET;
      addr_q    <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      rw_q      <= 1'b0;
      hi_q      <= 1'b0;
      lo_q      <= 1'b0;
      dtack_n_q <= 1'b1;
      busy_q    <= CLEAR_EN;
      rd_hi_q   <= 1'b0;
      rd_lo_q   <= 1'b0;
      wr_hi_q   <= 1'b0;
      wr_lo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      rw_q      <= rw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dtack_n_q <= dtack_n_d;
      busy_q    <= busy_d;
      rd_hi_q   <= rd_hi_d;
      rd_lo_q   <= rd_lo_d;
      wr_hi_q   <= wr_hi_d;
      wr_lo_q   <= wr_lo_d;
    end
  end

  // During fill, wr_hi_q marks that address addr_q has already been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR:   if (wr_hi_q && (addr_q == ADDR_LAST)) state_d = S_IDLE;
      S_IDLE:    if (w_start) state_d = S_ISSUE;
      S_ISSUE: begin
        if (bus_io.i_AS_n)  state_d = S_IDLE;
        else if (rw_q)      state_d = S_CAPTURE;
        else                state_d = S_ACK;
      end
      S_CAPTURE: state_d = bus_io.i_AS_n ? S_IDLE : S_ACK;
      S_ACK:     if (bus_io.i_AS_n) state_d = S_IDLE;
      default:   state_d = S_RESET;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    din_d     = din_q;
    dout_d    = dout_q;
    rw_d      = rw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rd_hi_d   = 1'b0;
    rd_lo_d   = 1'b0;
    wr_hi_d   = 1'b0;
    wr_lo_d   = 1'b0;
    busy_d    = (state_d == S_CLEAR);
    dtack_n_d = (state_d != S_ACK);
    case (state_q)
      S_CLEAR: begin
        if (state_d == S_CLEAR) begin
          wr_hi_d = 1'b1;
          wr_lo_d = 1'b1;
          din_d   = {CLEAR_VAL, CLEAR_VAL};
          addr_d  = wr_hi_q ? (addr_q + ADDR_ONE) : '0;
        end
      end
      S_IDLE: begin
        if (w_start) begin
          addr_d  = bus_io.i_CPU_ADDR;
          din_d   = bus_io.i_CPU_DIN;
          rw_d    = bus_io.i_RW;
          hi_d    = ~bus_io.i_UDS_n;
          lo_d    = ~bus_io.i_LDS_n;
          rd_hi_d = bus_io.i_RW & ~bus_io.i_UDS_n;
          rd_lo_d = bus_io.i_RW & ~bus_io.i_LDS_n;
          wr_hi_d = ~bus_io.i_RW & ~bus_io.i_UDS_n;
          wr_lo_d = ~bus_io.i_RW & ~bus_io.i_LDS_n;
        end
      end
      // An aborted read leaves the previous read data in place.
      S_CAPTURE: begin
        if (state_d == S_ACK) begin
          dout_d = {hi_q ? bus_io.i_RAM_DOUT_HI : 8'h00,
                    lo_q ? bus_io.i_RAM_DOUT_LO : 8'h00};
        end
      end
      default: ;
    endcase
  end

  assign bus_io.o_CPU_DOUT  = dout_q;
  assign bus_io.o_DTACK_n   = dtack_n_q;
  assign bus_io.o_BUSY      = busy_q;
  assign bus_io.o_RAM_ADDR  = addr_q;
  assign bus_io.o_RAM_DIN   = din_q;
  assign bus_io.o_RAM_RD_HI = rd_hi_q;
  assign bus_io.o_RAM_RD_LO = rd_lo_q;
  assign bus_io.o_RAM_WR_HI = wr_hi_q;
  assign bus_io.o_RAM_WR_LO = wr_lo_q;

endmodule
`default_nettype wire
